// File: rtl/adc_scheduler.sv
// Continuous-scan sequencer for AD7908/7918/7928 SPI ADCs.
// Define ADC_SCHED_DUMMY_EN for two power-up dummy frames after reset.
module adc_scheduler #(
  parameter int DIGITS    = 8,
  parameter int SCLK_DIV  = 2,
  parameter int QUIET_CYC = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [7:0]        i_ch_mask,
  input  logic [1:0]        i_pm,
  input  logic              i_range_sel,
  input  logic              i_in_slave,
  output logic              o_out_slave,
  output logic              o_cs,
  output logic              o_sclk,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [2:0]        o_res_chan,
  output logic [DIGITS-1:0] o_res_data,
  output logic              o_busy,
  output logic              o_overrun
);

`ifdef ADC_SCHED_DUMMY_EN
  localparam logic [1:0] DUMMY_N = 2'd2;
`else
  localparam logic [1:0] DUMMY_N = 2'd0;
`endif

  localparam logic [7:0]  DLAST = 8'(SCLK_DIV - 1);
  localparam logic [15:0] QLAST = 16'(QUIET_CYC - 1);
  localparam logic [4:0]  CLAST = 5'(DIGITS + 3);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_t;

  state_t              r_state;
  logic                r_cs;
  logic                r_sclk;
  logic                r_out;
  logic                r_valid;
  logic [2:0]          r_chan;
  logic [DIGITS-1:0]   r_data;
  logic                r_busy;
  logic                r_ovr;
  logic [2:0]          r_last;
  logic                r_fill;
  logic [1:0]          r_dummy;
  logic                r_dmy;
  logic [7:0]          r_div;
  logic [4:0]          r_bit;
  logic [15:0]         r_qcnt;
  logic [15:0]         r_word;
  logic [DIGITS+2:0]   r_sr;

  logic                w_dmy;
  logic                w_go;
  logic                w_qend;
  logic                w_start;
  logic                w_rise;
  logic                w_new;
  logic [2:0]          w_next;
  logic [15:0]         w_word;

  function automatic logic [2:0] f_next(
    input logic [7:0] m,
    input logic [2:0] last
  );
    logic [2:0] lo;
    logic [2:0] hi;
    logic       fh;
    lo = '0;
    hi = '0;
    fh = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lo = 3'(i);
      if (m[i] && (3'(i) > last)) begin
        hi = 3'(i);
        fh = 1'b1;
      end
    end
    return fh ? hi : lo;
  endfunction

  always_comb begin
    w_dmy   = (r_dummy != 2'd0);
    w_go    = w_dmy || (i_enable && (i_ch_mask != 8'h00));
    w_qend  = (r_state == QUIET) && (r_qcnt == QLAST);
    w_start = w_go && ((r_state == IDLE) || w_qend);
    w_next  = f_next(i_ch_mask, r_last);
    w_word  = w_dmy ? 16'hFFFF
                    : {3'b100, w_next, i_pm, 2'b00,
                       i_range_sel, 1'b1, 4'h0};
    w_rise  = (r_state == SHIFT) && (r_div == DLAST) && !r_sclk;
    w_new   = (r_state == QUIET) && (r_qcnt == 16'd0)
              && !r_dmy && !r_fill;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_cs    <= 1'b1;
      r_sclk  <= 1'b1;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
      r_chan  <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
      r_last  <= 3'd7;
      r_fill  <= 1'b1;
      r_dummy <= DUMMY_N;
      r_dmy   <= 1'b0;
      r_div   <= '0;
      r_bit   <= '0;
      r_qcnt  <= '0;
      r_word  <= '0;
      r_sr    <= '0;
    end else begin
      r_ovr <= w_new && r_valid && !i_res_ready;
      if (w_new) begin
        r_valid <= 1'b1;
        r_chan  <= r_sr[DIGITS+2 -: 3];
        r_data  <= r_sr[DIGITS-1:0];
      end else if (r_valid && i_res_ready) begin
        r_valid <= 1'b0;
      end
      unique case (r_state)
        IDLE: ;
        SETUP: begin
          r_state <= SHIFT;
          r_div   <= '0;
          r_bit   <= '0;
        end
        SHIFT: begin
          if (r_div == DLAST) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
          end else begin
            r_div <= r_div + 8'd1;
          end
          if (w_rise) begin
            // keep only the channel id and result bits of DOUT
            if (r_bit >= 5'd1 && r_bit <= CLAST)
              r_sr <= {r_sr[DIGITS+1:0], i_in_slave};
            r_word <= {r_word[14:0], 1'b0};
            r_bit  <= r_bit + 5'd1;
            if (r_bit == 5'd15) begin
              r_state <= QUIET;
              r_cs    <= 1'b1;
              r_out   <= 1'b0;
              r_qcnt  <= '0;
            end else begin
              r_out <= r_word[14];
            end
          end
        end
        QUIET: begin
          r_qcnt <= r_qcnt + 16'd1;
          if (r_qcnt == 16'd0 && !r_dmy)
            r_fill <= 1'b0;
          if (w_qend && !w_go) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_fill  <= 1'b1;
            r_last  <= 3'd7;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_start) begin
        r_state <= SETUP;
        r_cs    <= 1'b0;
        r_busy  <= 1'b1;
        r_out   <= w_word[15];
        r_word  <= w_word;
        r_dmy   <= w_dmy;
        if (w_dmy) r_dummy <= r_dummy - 2'd1;
        else       r_last  <= w_next;
      end
    end
  end

  assign o_cs        = r_cs;
  assign o_sclk      = r_sclk;
  assign o_out_slave = r_out;
  assign o_res_valid = r_valid;
  assign o_res_chan  = r_chan;
  assign o_res_data  = r_data;
  assign o_busy      = r_busy;
  assign o_overrun   = r_ovr;

endmodule
